mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single RAM port between the instruction cache and the data cache. Dcache requests have priority and hold the port for a full block burst: BURST word transfers, matching the 2-word cache frames. An icache request pending at the end of a dcache burst is served next, so neither requester starves. The block sits between the two L1 caches and the RAM model / memory controller. Only the RAM port is sequenced; cache contents are untouched.

## Interface
Parameters:
- WORD_W, 32, data/address width
- BURST, 2, words per dcache grant (words per cache frame); must be ≥1

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  WORD_W  icache word address
- iwait  out  1  low for exactly the cycle the icache word completes
- iload  out  WORD_W  read data to icache
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  WORD_W  dcache word address
- dstore  in  WORD_W  dcache write data
- dwait  out  1  low for exactly the cycle the dcache word completes
- dload  out  WORD_W  read data to dcache
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- owner  out  2  current grant: 0 none, 1 icache, 2 dcache

## Operation
- Registered state: state ∈ {IDLE, IGRANT, DGRANT}, beat counter (max(1, $clog2(BURST)) bits).
- Request definitions: dreq = dREN|dWEN; ack = (ramstate == ACCESS).
- IDLE:
  - drives ramREN = ramWEN = 0 and ramaddr = ramstore = 0.
  - next state: if dreq then DGRANT; else if iREN then IGRANT; else IDLE.
- DGRANT:
  - routing: ramaddr = daddr, ramstore = dstore, ramWEN = dWEN, ramREN = dREN & ~dWEN. When dREN and dWEN are both high, the write wins.
  - on ack: dwait = 0 and beat increments.
    - If beat == BURST-1: beat clears to 0; next state is IGRANT if iREN, else IDLE.
    - Otherwise: stay in DGRANT (the lock holds even when iREN is high).
  - dreq = 0 without ack: beat clears to 0, go to IDLE (burst abandoned).
- IGRANT:
  - routing: ramaddr = iaddr, ramREN = iREN, ramWEN = 0, ramstore = 0.
  - on ack: iwait = 0, go to IDLE. IDLE then prefers the dcache, so grants alternate under contention.
  - iREN = 0 without ack: go to IDLE.
- Wait signals: the non-owner's wait is always 1. The owner's wait is ~ack.
- Load data: iload = dload = ramload, combinational and ungated. Callers sample it only on their wait-low cycle.
- ERROR / BUSY / FREE while granted: owner's wait stays 1, beat does not advance, state holds.
- owner reflects the registered state: 0 in IDLE, 1 in IGRANT, 2 in DGRANT.

## Timing
- Reset values: state IDLE, beat 0, ramREN = ramWEN = 0, ramaddr = ramstore = 0, iwait = dwait = 1, owner = 0.
- Reset is asynchronous and may assert mid-burst; there is no recovery of a partial burst.
- Grant latency: a request seen in IDLE at cycle t is driven to the RAM at t+1. There is one bubble cycle per grant from IDLE.
- Hand-off from a completed dcache burst to a pending icache request has no bubble: IGRANT starts the next cycle.
- The dcache's BURST words are back-to-back under a single grant. The dcache may change daddr/dstore between beats.
- Simultaneous dreq and iREN in IDLE: the dcache wins. The icache is guaranteed the slot after that burst.
- Request dropped in the same cycle as ack: the beat counts as completed.
- All RAM-side outputs are combinational from state and the selected requester. There is no output register.

## Structure
- ramstate_t comes from cpu_types_pkg.
- Add arb_state_t {IDLE, IGRANT, DGRANT} to cpu_types_pkg so bench monitors can decode the state.
- Single module with no sub-module: one always_ff for state/beat and one always_comb for routing and next-state.

## Test plan
- Reset mid-DGRANT after beat 0 acked → all outputs at reset values immediately; owner = 0; the next dREN is re-granted from beat 0.
- iREN alone, iaddr = 0x40, RAM acks 2 cycles after grant → ramREN high from t+1, iwait low for exactly 1 cycle, iload = ramload, then IDLE.
- dWEN with iREN held high, BURST = 2, daddr 0x80 then 0x84 → two writes with ramWEN and no icache access in between; IGRANT on the cycle after the second ack, with no bubble.
- dREN and dWEN both high → ramWEN = 1, ramREN = 0.
- dREN dropped before ack → IDLE, beat = 0.
- ramstate = ERROR for 3 cycles during DGRANT → dwait held at 1, beat unchanged; normal completion once ramstate returns to ACCESS.
- dREN and iREN both held high for 20 cycles, RAM acking every cycle → ownership alternates DGRANT(2 beats) / IGRANT(1 beat); the icache gets at least 1 word per 4 cycles.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state and memory arbiter state.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FREE,
      BUSY,
      ACCESS,
      ERROR
   } ramstate_t;

   // Encoding doubles as the arbiter's owner output: 0 none, 1 icache, 2 dcache.
   typedef enum logic [1:0] {
      IDLE,
      IGRANT,
      DGRANT
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between icache and dcache; dcache has priority and
// holds the port for a BURST-word block, and a waiting icache is served right after.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned BURST  = 2
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  ramstate_t         ramstate,
   output logic [1:0]        owner
);

   localparam int unsigned BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

   arb_state_t        state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              dreq;
   logic              ack;

   assign dreq  = dREN | dWEN;
   assign ack   = (ramstate == ACCESS);
   assign iload = ramload;
   assign dload = ramload;
   assign owner = state_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (dreq) begin
               state_d = DGRANT;
            end else if (iREN) begin
               state_d = IGRANT;
            end
         end
         DGRANT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            // An ack counts even if the request drops in the same cycle.
            if (ack) begin
               dwait = 1'b0;
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = iREN ? IGRANT : IDLE;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end else if (!dreq) begin
               beat_d  = '0;
               state_d = IDLE;
            end
         end
         IGRANT: begin
            ramaddr = iaddr;
            ramREN  = iREN;
            if (ack) begin
               iwait   = 1'b0;
               state_d = IDLE;
            end else if (!iREN) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            beat_d  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter, checked every cycle against a
// grant/burst-progress model plus hand-computed expectations.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BURST  = 2;

   logic              CLK = 1'b0;
   logic              nRST;
   logic              iREN;
   logic [WORD_W-1:0] iaddr;
   logic              iwait;
   logic [WORD_W-1:0] iload;
   logic              dREN;
   logic              dWEN;
   logic [WORD_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   logic              dwait;
   logic [WORD_W-1:0] dload;
   logic              ramREN;
   logic              ramWEN;
   logic [WORD_W-1:0] ramaddr;
   logic [WORD_W-1:0] ramstore;
   logic [WORD_W-1:0] ramload;
   ramstate_t         ramstate;
   logic [1:0]        owner;

   int n_checks = 0;
   int n_errors = 0;

   // Model: who holds the port (0 none, 1 icache, 2 dcache) and words done in this burst.
   int m_own  = 0;
   int m_done = 0;
   int i_words, d_words;

   mem_arbiter #(.WORD_W(WORD_W), .BURST(BURST)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .owner(owner)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running, need finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      logic ack;
      ack = (ramstate == ACCESS);
      chk("owner", 64'(owner), 64'(m_own));
      chk("ramaddr", 64'(ramaddr),
          64'((m_own == 2) ? daddr : (m_own == 1) ? iaddr : '0));
      chk("ramstore", 64'(ramstore), 64'((m_own == 2) ? dstore : '0));
      chk("ramWEN", 64'(ramWEN), 64'(m_own == 2 && dWEN));
      chk("ramREN", 64'(ramREN),
          64'((m_own == 2) ? (dREN && !dWEN) : (m_own == 1) ? iREN : 1'b0));
      chk("iwait", 64'(iwait), 64'(!(m_own == 1 && ack)));
      chk("dwait", 64'(dwait), 64'(!(m_own == 2 && ack)));
      chk("iload", 64'(iload), 64'(ramload));
      chk("dload", 64'(dload), 64'(ramload));
   endtask

   task automatic model_update();
      logic ack;
      ack = (ramstate == ACCESS);
      if (!nRST) begin
         m_own  = 0;
         m_done = 0;
      end else if (m_own == 0) begin
         m_own = (dREN || dWEN) ? 2 : iREN ? 1 : 0;
      end else if (m_own == 2) begin
         if (ack) begin
            d_words++;
            m_done++;
            if (m_done == BURST) begin
               m_done = 0;
               m_own  = iREN ? 1 : 0;
            end
         end else if (!(dREN || dWEN)) begin
            m_done = 0;
            m_own  = 0;
         end
      end else begin
         if (ack) i_words++;
         if (ack || !iREN) m_own = 0;
      end
   endtask

   // Inputs are set at the falling edge; sample 1ns later, well away from the rising edge.
   task automatic step();
      #1;
      check_model();
   endtask

   task automatic adv();
      @(posedge CLK);
      model_update();
      @(negedge CLK);
   endtask

   task automatic drive(input logic i, input logic dr, input logic dw, input ramstate_t rs);
      iREN     = i;
      dREN     = dr;
      dWEN     = dw;
      ramstate = rs;
   endtask

   initial begin
      nRST = 1'b0;
      drive(1'b0, 1'b0, 1'b0, FREE);
      iaddr = '0; daddr = '0; dstore = '0; ramload = 32'h1234_5678;
      #1;
      chk("rst_owner", 64'(owner), 64'd0);
      chk("rst_iwait", 64'(iwait), 64'd1);
      chk("rst_dwait", 64'(dwait), 64'd1);
      chk("rst_ramREN", 64'(ramREN), 64'd0);
      chk("rst_ramaddr", 64'(ramaddr), 64'd0);
      @(negedge CLK);
      @(negedge CLK);
      nRST = 1'b1;

      // Reset mid-burst, then a fresh burst must run its full two beats.
      drive(1'b0, 1'b1, 1'b0, ACCESS);
      daddr = 32'h100;
      step(); adv();
      step(); chk("mr_dwait0", 64'(dwait), 64'd0); adv();
      nRST = 1'b0;
      m_own = 0; m_done = 0;
      step();
      chk("mr_owner", 64'(owner), 64'd0);
      chk("mr_ramREN", 64'(ramREN), 64'd0);
      chk("mr_dwait", 64'(dwait), 64'd1);
      chk("mr_ramaddr", 64'(ramaddr), 64'd0);
      adv();
      nRST = 1'b1;
      step(); adv();
      step(); chk("mr_beat0", 64'(dwait), 64'd0); adv();
      step(); chk("mr_beat1_owner", 64'(owner), 64'd2); adv();
      drive(1'b0, 1'b0, 1'b0, FREE);
      step(); chk("mr_done", 64'(owner), 64'd0); adv();

      // Lone icache read, acked two cycles after grant.
      iaddr = 32'h40; ramload = 32'hDEAD_BEEF;
      drive(1'b1, 1'b0, 1'b0, FREE);
      step(); chk("i_bubble", 64'(ramREN), 64'd0); adv();
      ramstate = BUSY;
      step();
      chk("i_ren", 64'(ramREN), 64'd1);
      chk("i_addr", 64'(ramaddr), 64'h40);
      adv();
      step(); chk("i_busy_wait", 64'(iwait), 64'd1); adv();
      ramstate = ACCESS;
      step();
      chk("i_ack_wait", 64'(iwait), 64'd0);
      chk("i_load", 64'(iload), 64'hDEAD_BEEF);
      adv();
      drive(1'b0, 1'b0, 1'b0, FREE);
      step(); chk("i_idle", 64'(owner), 64'd0); adv();

      // Two-beat dcache write burst with icache waiting: no bubble before IGRANT.
      drive(1'b1, 1'b0, 1'b1, ACCESS);
      daddr = 32'h80; dstore = 32'h11;
      step(); adv();
      step();
      chk("dw_wen0", 64'(ramWEN), 64'd1);
      chk("dw_ren0", 64'(ramREN), 64'd0);
      chk("dw_addr0", 64'(ramaddr), 64'h80);
      adv();
      daddr = 32'h84; dstore = 32'h22;
      step();
      chk("dw_owner1", 64'(owner), 64'd2);
      chk("dw_addr1", 64'(ramaddr), 64'h84);
      chk("dw_store1", 64'(ramstore), 64'h22);
      adv();
      dWEN = 1'b0;
      step();
      chk("dw_handoff", 64'(owner), 64'd1);
      chk("dw_handoff_iwait", 64'(iwait), 64'd0);
      adv();
      drive(1'b0, 1'b0, 1'b0, FREE);
      step(); adv();

      // Read+write together: write wins. One beat, then drop -> abandon.
      drive(1'b0, 1'b1, 1'b1, FREE);
      step(); adv();
      ramstate = ACCESS;
      step();
      chk("rw_wen", 64'(ramWEN), 64'd1);
      chk("rw_ren", 64'(ramREN), 64'd0);
      adv();
      drive(1'b0, 1'b0, 1'b0, FREE);
      step(); adv();
      step(); chk("drop_idle", 64'(owner), 64'd0);

      // ERROR stall; the burst must restart from beat 0 after the abandon above.
      drive(1'b0, 1'b1, 1'b0, FREE);
      adv();
      ramstate = ERROR;
      for (int k = 0; k < 3; k++) begin
         step(); chk("err_dwait", 64'(dwait), 64'd1); adv();
      end
      ramstate = ACCESS;
      step(); chk("err_beat0", 64'(dwait), 64'd0); adv();
      step(); chk("err_beat1_owner", 64'(owner), 64'd2); adv();
      drive(1'b0, 1'b0, 1'b0, FREE);
      step(); chk("err_end", 64'(owner), 64'd0); adv();

      // Sustained contention: D,D,I then one IDLE bubble per 4 cycles.
      i_words = 0; d_words = 0;
      drive(1'b1, 1'b1, 1'b0, ACCESS);
      for (int k = 0; k < 20; k++) begin
         step(); adv();
      end
      chk("cont_iwords", 64'(i_words), 64'd5);
      chk("cont_dwords", 64'(d_words), 64'd10);
      drive(1'b0, 1'b0, 1'b0, FREE);
      step(); adv();
      step(); adv();

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         iREN   = ($urandom_range(0, 3) != 0);
         dREN   = ($urandom_range(0, 2) == 0);
         dWEN   = ($urandom_range(0, 3) == 0);
         iaddr  = $urandom;
         daddr  = $urandom;
         dstore = $urandom;
         ramload = $urandom;
         if ($urandom_range(0, 1) == 1) ramstate = ACCESS;
         else ramstate = ramstate_t'($urandom_range(0, 3));
         step(); adv();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
